id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
Parametrised ID/EX pipeline register between decode and execute in the 5-stage core. Adds to the previous-generation latch:
- a valid bit
- stall (hold) support
- deterministic bubble insertion (zeros, never X)
- a multi-cycle squash window after a taken branch

Widths and squash depth are generics, so the same block serves the 32-bit core and narrower variants.

Parameters:
DATA_W, 32, width of read_data1/2, im_ext, im_addr, pc
CTRL_W, 9, width of the control-signal bundle
FUNC_W, 6, width of the function field
REG_W, 5, register-specifier width (rs/rt/rd)
SQUASH_DEPTH, 1, number of consecutive captures turned into bubbles per flush request (1..15)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
flush  in  1  taken-branch squash request
stall  in  1  hold current contents (hazard unit)
in_valid  in  1  decode stage holds a real instruction
pc_in  in  DATA_W  instruction PC
read_data1_in  in  DATA_W  rs operand
read_data2_in  in  DATA_W  rt operand
im_ext_in  in  DATA_W  sign-extended immediate
im_addr_in  in  DATA_W  jump/branch target address
func_in  in  FUNC_W  function field
ctrl_sig_in  in  CTRL_W  decoded control bundle
rs_in, rt_in, rd_in  in  REG_W each  register specifiers
valid_out  out  1  execute-stage instruction is real
pc_out, read_data1, read_data2, im_ext, im_addr_out  out  DATA_W  registered copies
func  out  FUNC_W  registered func
ctrl_sig  out  CTRL_W  registered control; all-zero when bubble
rs_out, rt_out, rd  out  REG_W  registered specifiers
squash_busy  out  1  squash window active (sq_cnt != 0)

Behaviour:
- All state updates on rising clk only; no latches and no level-sensitive blocks.
- Reset: when rst=1 at the edge, all outputs become 0, valid_out=0 and sq_cnt=0. Reset overrides everything, including mid-squash.
- Priority at each edge: rst > flush > squash window > stall > load.
- flush=1: the register captures a bubble. sq_cnt <= SQUASH_DEPTH-1. Flush ignores stall, because a squashed instruction must not be held.
- Squash window (sq_cnt!=0, flush=0, stall=0): the register captures a bubble and sq_cnt decrements.
- Squash window with stall=1: contents and sq_cnt are held.
- flush re-asserted during a window reloads sq_cnt to SQUASH_DEPTH-1; there is no accumulation.
- Bubble: valid_out=0 and every data/control/specifier output = 0. rd=0 makes writeback and forwarding target r0, which is harmless.
- stall=1 (no flush, no window): all outputs hold their values, including valid_out.
- Load (none of the above): all outputs take their _in values and valid_out <= in_valid.
- in_valid=0 load: fields are copied but ctrl_sig is forced to 0, so execute sees no side-effecting control.
- Latency: 1 cycle input-to-output. There is no combinational path from any input to any output.
- squash_busy is a registered compare, (sq_cnt!=0). sq_cnt width = clog2(SQUASH_DEPTH+1), minimum 1.
- SQUASH_DEPTH=1: no window; behaviour reduces to a one-cycle flush.

Optional Feature:
Macro ID_EX_STATS_EN.
- Defined: adds output ports bubble_cnt and stall_cnt, 32 bits each.
  - bubble_cnt increments on every edge that captures a bubble (flush or window).
  - stall_cnt increments on every edge where stall causes a hold.
  - Both saturate at all-ones and clear on rst.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Package id_ex_pkg holds:
  - default width constants (DATA_W_D=32, CTRL_W_D=9, FUNC_W_D=6, REG_W_D=5)
  - CTRL_NOP = all-zero
  - a packed struct id_ex_fields_t bundling all payload fields, for bench comparison
- One sub-module is natural: squash_ctr. It owns sq_cnt, takes flush/stall/rst and outputs a bubble-select and squash_busy. The payload register stays flat in the top.

Test Plan:
- Reset: drive random inputs, rst=1 for 2 cycles -> all outputs 0, valid_out=0, squash_busy=0.
- Load: in_valid=1, pc_in=0x40, read_data1_in=0xDEADBEEF, rd_in=7, ctrl_sig_in=0x1A5 -> next cycle the outputs match and valid_out=1.
- Stall: load pc 0x40, then stall=1 for 3 cycles while pc_in=0x44 -> pc_out stays 0x40 and valid_out stays 1. Release -> pc_out=0x44.
- Flush beats stall: SQUASH_DEPTH=3, flush=1 and stall=1 in the same cycle -> bubble (all 0, valid_out=0), squash_busy=1.
  - Two more unstalled cycles -> 2 more bubbles.
  - Third cycle -> loads pc_in normally, squash_busy=0.
- Window plus stall, then re-flush: SQUASH_DEPTH=3, flush; then stall 2 cycles in the window -> sq_cnt held at 2. Then flush again -> sq_cnt=2 again (reload, no accumulation).
- in_valid=0 load with ctrl_sig_in=0x1FF -> ctrl_sig=0 and valid_out=0. With ID_EX_STATS_EN defined, 5 flushes plus 4 stalls -> bubble_cnt=5 and stall_cnt=4.

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared types and default widths for the ID/EX pipeline register.
// Related build option: ID_EX_STATS_EN adds bubble/stall statistics counters
// to id_ex_pipe_reg.
package id_ex_pkg;

    localparam int DATA_W_D = 32;
    localparam int CTRL_W_D = 9;
    localparam int FUNC_W_D = 6;
    localparam int REG_W_D  = 5;

    // Control bundle value that has no side effects in execute
    localparam logic [CTRL_W_D-1:0] CTRL_NOP = {CTRL_W_D{1'b0}};

    // All payload fields at default widths, in one comparable unit
    typedef struct packed {
        logic [DATA_W_D-1:0] pc;
        logic [DATA_W_D-1:0] rd1;
        logic [DATA_W_D-1:0] rd2;
        logic [DATA_W_D-1:0] im_ext;
        logic [DATA_W_D-1:0] im_addr;
        logic [FUNC_W_D-1:0] func;
        logic [CTRL_W_D-1:0] ctrl;
        logic [REG_W_D-1:0]  rs;
        logic [REG_W_D-1:0]  rt;
        logic [REG_W_D-1:0]  rd;
    } id_ex_fields_t;

endpackage

// File: rtl/id_ex_pipe_reg_squash_ctr.sv
// Squash-window counter: turns one flush request into SQUASH_DEPTH
// consecutive bubble captures. A stall freezes the window; a new flush
// reloads it rather than extending it.
module squash_ctr #(
    parameter int SQUASH_DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic stall,
    output logic bubble_sel,
    output logic squash_busy
);

    localparam int CNT_W = ($clog2(SQUASH_DEPTH + 1) < 1) ? 1 : $clog2(SQUASH_DEPTH + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SQUASH_DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO   = CNT_W'(0);

    logic [CNT_W-1:0] sq_cnt_q;
    logic [CNT_W-1:0] sq_cnt_d;
    logic             busy_q;
    logic             busy_d;
    logic             window_s;

    assign window_s    = (sq_cnt_q != ZERO);
    assign bubble_sel  = flush | (window_s & ~stall);
    assign squash_busy = busy_q;

    // Next window count: flush reloads, an unstalled window step counts down
    always_comb begin
        sq_cnt_d = sq_cnt_q;
        if (flush) begin
            sq_cnt_d = RELOAD;
        end else if (window_s && !stall) begin
            sq_cnt_d = sq_cnt_q - ONE;
        end else begin
            sq_cnt_d = sq_cnt_q;
        end
        busy_d = (sq_cnt_d != ZERO);
    end

    // Window count and its registered busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            sq_cnt_q <= ZERO;
            busy_q   <= 1'b0;
        end else begin
            sq_cnt_q <= sq_cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid bit, stall hold, zero bubbles and a
// multi-cycle squash window after a taken branch.
// Build option: define ID_EX_STATS_EN to add the bubble_cnt / stall_cnt
// saturating statistics outputs.
module id_ex_pipe_reg
    import id_ex_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int CTRL_W       = 9,
    parameter int FUNC_W       = 6,
    parameter int REG_W        = 5,
    parameter int SQUASH_DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] read_data1_in,
    input  logic [DATA_W-1:0] read_data2_in,
    input  logic [DATA_W-1:0] im_ext_in,
    input  logic [DATA_W-1:0] im_addr_in,
    input  logic [FUNC_W-1:0] func_in,
    input  logic [CTRL_W-1:0] ctrl_sig_in,
    input  logic [REG_W-1:0]  rs_in,
    input  logic [REG_W-1:0]  rt_in,
    input  logic [REG_W-1:0]  rd_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] im_ext,
    output logic [DATA_W-1:0] im_addr_out,
    output logic [FUNC_W-1:0] func,
    output logic [CTRL_W-1:0] ctrl_sig,
    output logic [REG_W-1:0]  rs_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [REG_W-1:0]  rd,
    output logic              squash_busy
`ifdef ID_EX_STATS_EN
    ,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    logic bubble_sel_s;
    logic hold_sel_s;

    logic              valid_q,   valid_d;
    logic [DATA_W-1:0] pc_q,      pc_d;
    logic [DATA_W-1:0] rd1_q,     rd1_d;
    logic [DATA_W-1:0] rd2_q,     rd2_d;
    logic [DATA_W-1:0] im_ext_q,  im_ext_d;
    logic [DATA_W-1:0] im_addr_q, im_addr_d;
    logic [FUNC_W-1:0] func_q,    func_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [REG_W-1:0]  rs_q,      rs_d;
    logic [REG_W-1:0]  rt_q,      rt_d;
    logic [REG_W-1:0]  rd_q,      rd_d;

    squash_ctr #(
        .SQUASH_DEPTH (SQUASH_DEPTH)
    ) u_squash_ctr (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .stall       (stall),
        .bubble_sel  (bubble_sel_s),
        .squash_busy (squash_busy)
    );

    // A flush is never held, so stall only holds when no flush is pending
    assign hold_sel_s = stall & ~flush;

    // Next payload: bubble beats hold beats load; invalid loads drop control
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        rd1_d     = rd1_q;
        rd2_d     = rd2_q;
        im_ext_d  = im_ext_q;
        im_addr_d = im_addr_q;
        func_d    = func_q;
        ctrl_d    = ctrl_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        if (bubble_sel_s) begin
            valid_d   = 1'b0;
            pc_d      = '0;
            rd1_d     = '0;
            rd2_d     = '0;
            im_ext_d  = '0;
            im_addr_d = '0;
            func_d    = '0;
            ctrl_d    = '0;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
        end else if (hold_sel_s) begin
            valid_d   = valid_q;
        end else begin
            valid_d   = in_valid;
            pc_d      = pc_in;
            rd1_d     = read_data1_in;
            rd2_d     = read_data2_in;
            im_ext_d  = im_ext_in;
            im_addr_d = im_addr_in;
            func_d    = func_in;
            ctrl_d    = in_valid ? ctrl_sig_in : '0;
            rs_d      = rs_in;
            rt_d      = rt_in;
            rd_d      = rd_in;
        end
    end

    // Payload register, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            im_ext_q  <= '0;
            im_addr_q <= '0;
            func_q    <= '0;
            ctrl_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            im_ext_q  <= im_ext_d;
            im_addr_q <= im_addr_d;
            func_q    <= func_d;
            ctrl_q    <= ctrl_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
        end
    end

    assign valid_out   = valid_q;
    assign pc_out      = pc_q;
    assign read_data1  = rd1_q;
    assign read_data2  = rd2_q;
    assign im_ext      = im_ext_q;
    assign im_addr_out = im_addr_q;
    assign func        = func_q;
    assign ctrl_sig    = ctrl_q;
    assign rs_out      = rs_q;
    assign rt_out      = rt_q;
    assign rd          = rd_q;

`ifdef ID_EX_STATS_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] stall_cnt_q,  stall_cnt_d;

    // Saturating event counters for captured bubbles and stall holds
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (bubble_sel_s && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
        if (hold_sel_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Statistics registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= 32'd0;
            stall_cnt_q  <= 32'd0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg with SQUASH_DEPTH=3.
module tb_id_ex_pipe_reg;
    import id_ex_pkg::*;

    typedef struct packed {
        logic          v;
        logic          b;
        id_ex_fields_t f;
    } exp_t;

    logic clk = 1'b0;
    logic rst, flush, stall, in_valid;
    id_ex_fields_t in_f;

    logic          valid_out, squash_busy;
    logic [31:0]   pc_out, read_data1, read_data2, im_ext, im_addr_out;
    logic [5:0]    func;
    logic [8:0]    ctrl_sig;
    logic [4:0]    rs_out, rt_out, rd;
`ifdef ID_EX_STATS_EN
    logic [31:0]   bubble_cnt, stall_cnt;
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(
        .DATA_W(32), .CTRL_W(9), .FUNC_W(6), .REG_W(5), .SQUASH_DEPTH(3)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall), .in_valid(in_valid),
        .pc_in(in_f.pc), .read_data1_in(in_f.rd1), .read_data2_in(in_f.rd2),
        .im_ext_in(in_f.im_ext), .im_addr_in(in_f.im_addr), .func_in(in_f.func),
        .ctrl_sig_in(in_f.ctrl), .rs_in(in_f.rs), .rt_in(in_f.rt), .rd_in(in_f.rd),
        .valid_out(valid_out), .pc_out(pc_out), .read_data1(read_data1),
        .read_data2(read_data2), .im_ext(im_ext), .im_addr_out(im_addr_out),
        .func(func), .ctrl_sig(ctrl_sig), .rs_out(rs_out), .rt_out(rt_out), .rd(rd),
        .squash_busy(squash_busy)
`ifdef ID_EX_STATS_EN
        , .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
`endif
    );

    function automatic id_ex_fields_t mkf(input logic [31:0] pc, input logic [31:0] rd1,
                                          input logic [8:0] ctrl, input logic [4:0] rdn);
        id_ex_fields_t f;
        f.pc      = pc;
        f.rd1     = rd1;
        f.rd2     = 32'h1234_5678;
        f.im_ext  = 32'hFFFF_FFF0;
        f.im_addr = 32'h0000_0100;
        f.func    = 6'h2A;
        f.ctrl    = ctrl;
        f.rs      = 5'd3;
        f.rt      = 5'd4;
        f.rd      = rdn;
        return f;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Drive one cycle and post the expected post-edge state
    task automatic step(input logic r, input logic fl, input logic st, input logic iv,
                        input id_ex_fields_t f, input logic ev, input logic eb,
                        input id_ex_fields_t ef);
        exp_t e;
        rst = r; flush = fl; stall = st; in_valid = iv; in_f = f;
        @(posedge clk);
        e.v = ev; e.b = eb; e.f = ef;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare DUT outputs against the oldest expectation
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            id_ex_fields_t got;
            e = exp_q.pop_front();
            got.pc = pc_out; got.rd1 = read_data1; got.rd2 = read_data2;
            got.im_ext = im_ext; got.im_addr = im_addr_out; got.func = func;
            got.ctrl = ctrl_sig; got.rs = rs_out; got.rt = rt_out; got.rd = rd;
            check("valid_out", 256'(valid_out), 256'(e.v));
            check("squash_busy", 256'(squash_busy), 256'(e.b));
            check("payload", 256'(got), 256'(e.f));
        end
    end

    initial begin
        id_ex_fields_t Z, A, B, C, D, E, E_exp, R;
        Z = '0;
        A = mkf(32'h0000_0040, 32'hDEAD_BEEF, 9'h1A5, 5'd7);
        B = mkf(32'h0000_0044, 32'h0000_1111, 9'h0C3, 5'd8);
        C = mkf(32'h0000_0080, 32'h0000_2222, 9'h011, 5'd9);
        D = mkf(32'h0000_00C0, 32'h0000_3333, 9'h100, 5'd10);
        E = mkf(32'h0000_0100, 32'h0000_4444, 9'h1FF, 5'd11);
        E_exp = E; E_exp.ctrl = 9'h000;
        rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; in_f = '0;
        @(negedge clk);

        // reset with random inputs
        for (int i = 0; i < 2; i++) begin
            R = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), R, 1'b0, 1'b0, Z);
        end
        // load
        step(1'b0, 1'b0, 1'b0, 1'b1, A, 1'b1, 1'b0, A);
        // stall holds for 3 cycles, then release loads B
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, B, 1'b1, 1'b0, A);
        step(1'b0, 1'b0, 1'b0, 1'b1, B, 1'b1, 1'b0, B);
        // flush beats stall, then two window bubbles, then normal load
        step(1'b0, 1'b1, 1'b1, 1'b1, C, 1'b0, 1'b1, Z);
        step(1'b0, 1'b0, 1'b0, 1'b1, C, 1'b0, 1'b1, Z);
        step(1'b0, 1'b0, 1'b0, 1'b1, C, 1'b0, 1'b0, Z);
        step(1'b0, 1'b0, 1'b0, 1'b1, C, 1'b1, 1'b0, C);
        // window held by stall, then re-flush reloads (exactly two more bubbles)
        step(1'b0, 1'b1, 1'b0, 1'b1, D, 1'b0, 1'b1, Z);
        step(1'b0, 1'b0, 1'b1, 1'b1, D, 1'b0, 1'b1, Z);
        step(1'b0, 1'b0, 1'b1, 1'b1, D, 1'b0, 1'b1, Z);
        step(1'b0, 1'b1, 1'b0, 1'b1, D, 1'b0, 1'b1, Z);
        step(1'b0, 1'b0, 1'b0, 1'b1, D, 1'b0, 1'b1, Z);
        step(1'b0, 1'b0, 1'b0, 1'b1, D, 1'b0, 1'b0, Z);
        step(1'b0, 1'b0, 1'b0, 1'b1, D, 1'b1, 1'b0, D);
        // invalid load: fields copied, control dropped
        step(1'b0, 1'b0, 1'b0, 1'b0, E, 1'b0, 1'b0, E_exp);
        // reset mid-squash, then 5 flushes and 4 stalls
        step(1'b0, 1'b1, 1'b0, 1'b1, A, 1'b0, 1'b1, Z);
        step(1'b1, 1'b0, 1'b0, 1'b1, A, 1'b0, 1'b0, Z);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1, A, 1'b0, 1'b1, Z);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, A, 1'b0, 1'b1, Z);
`ifdef ID_EX_STATS_EN
        check("bubble_cnt", 256'(bubble_cnt), 256'(32'd5));
        check("stall_cnt", 256'(stall_cnt), 256'(32'd4));
`endif
        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
